operand_fetch_stage: RTL

- Decode-side operand fetch and ID/EX pipeline register for the 32-bit pipelined processor.
- Upstream: the IF/ID register. It drives register-file read addresses from the decoded instruction and captures the register-file read data.
- Optionally bypasses the same-cycle writeback.
- Detects load-use hazards and inserts one bubble per hazard.
- Presents a registered, valid/ready-handshaked operand bundle to the execute stage.

---
 rtl/operand_fetch_stage.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/operand_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : operand_fetch_stage
// Purpose  : Decode-side operand fetch and ID/EX pipeline register. It selects
//            the operands, inserts one bubble per load-use hazard and hands a
//            registered, valid/ready operand bundle to the execute stage.
// Options  : OPERAND_FETCH_WB_BYPASS_EN - bypass same-cycle writeback data
//            into the operand mux. Use it with a register file that writes at
//            the clock edge.
// Revision : 1.0 - initial release
// ============================================================================
module operand_fetch_stage #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  output logic              id_ready,
  input  logic [ADDR_W-1:0] id_rs,
  input  logic [ADDR_W-1:0] id_rt,
  input  logic [ADDR_W-1:0] id_rd,
  input  logic              id_uses_rt,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic [DATA_W-1:0] id_imm,
  output logic [ADDR_W-1:0] rf_addr_a,
  output logic [ADDR_W-1:0] rf_addr_b,
  input  logic [DATA_W-1:0] rf_data_a,
  input  logic [DATA_W-1:0] rf_data_b,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              flush,
  input  logic              ex_ready,
  output logic              ex_valid,
  output logic [DATA_W-1:0] ex_op_a,
  output logic [DATA_W-1:0] ex_op_b,
  output logic [DATA_W-1:0] ex_imm,
  output logic [ADDR_W-1:0] ex_rs,
  output logic [ADDR_W-1:0] ex_rt,
  output logic [ADDR_W-1:0] ex_rd,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic [CNT_W-1:0]  bubble_count
);

`ifdef OPERAND_FETCH_WB_BYPASS_EN
  localparam logic c_BYPASS_EN = 1'b1;
`else
  // The register file writes through, so wb_* is never consulted here.
  localparam logic c_BYPASS_EN = 1'b0;
`endif

  localparam logic [0:0] c_ST_RUN    = 1'b0;
  localparam logic [0:0] c_ST_BUBBLE = 1'b1;

  logic [0:0]        r_state;
  logic [0:0]        w_stateNext;
  logic              w_countBubble;

  logic              r_exValid;
  logic [DATA_W-1:0] r_exOpA;
  logic [DATA_W-1:0] r_exOpB;
  logic [DATA_W-1:0] r_exImm;
  logic [ADDR_W-1:0] r_exRs;
  logic [ADDR_W-1:0] r_exRt;
  logic [ADDR_W-1:0] r_exRd;
  logic              r_exRegWrite;
  logic              r_exMemRead;
  logic [CNT_W-1:0]  r_bubbleCount;

  logic              w_bypA;
  logic              w_bypB;
  logic [DATA_W-1:0] w_opA;
  logic [DATA_W-1:0] w_opB;
  logic              w_hazard;
  logic              w_adv;

  assign rf_addr_a = id_rs;
  assign rf_addr_b = id_rt;

  // A writeback to r0 never matches because r0 is forced to zero first.
  assign w_bypA = c_BYPASS_EN && wb_en && (wb_addr == id_rs);
  assign w_bypB = c_BYPASS_EN && wb_en && (wb_addr == id_rt);

  // Operand select: r0 reads zero, then writeback bypass, then register file.
  always_comb begin
    w_opA = '0;
    w_opB = '0;
    if (id_rs != '0) begin
      w_opA = w_bypA ? wb_data : rf_data_a;
    end
    if (id_uses_rt && (id_rt != '0)) begin
      w_opB = w_bypB ? wb_data : rf_data_b;
    end
  end

  // A load in ID/EX whose destination is read by the instruction in ID.
  assign w_hazard = id_valid && r_exValid && r_exMemRead && (r_exRd != '0) &&
                    ((r_exRd == id_rs) || (id_uses_rt && (r_exRd == id_rt)));

  assign w_adv    = !r_exValid || ex_ready;
  assign id_ready = flush || (w_adv && !w_hazard);

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= c_ST_RUN;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // FSM next state: enter BUBBLE on an inserted bubble, leave on next advance.
  always_comb begin
    w_stateNext = r_state;
    if (flush) begin
      w_stateNext = c_ST_RUN;
    end else begin
      case (r_state)
        c_ST_RUN:    if (w_adv && w_hazard) w_stateNext = c_ST_BUBBLE;
        c_ST_BUBBLE: if (w_adv)             w_stateNext = c_ST_RUN;
        default:                            w_stateNext = c_ST_RUN;
      endcase
    end
  end

  // FSM output: a counted bubble is only possible from RUN.
  always_comb begin
    w_countBubble = 1'b0;
    if ((r_state == c_ST_RUN) && !flush && w_adv && w_hazard) begin
      w_countBubble = 1'b1;
    end
  end

  // ID/EX register: flush beats bubble beats load; hold when not advancing.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_exValid     <= 1'b0;
      r_exOpA       <= '0;
      r_exOpB       <= '0;
      r_exImm       <= '0;
      r_exRs        <= '0;
      r_exRt        <= '0;
      r_exRd        <= '0;
      r_exRegWrite  <= 1'b0;
      r_exMemRead   <= 1'b0;
      r_bubbleCount <= '0;
    end else if (flush) begin
      r_exValid    <= 1'b0;
      r_exRegWrite <= 1'b0;
      r_exMemRead  <= 1'b0;
    end else if (w_adv) begin
      if (w_hazard) begin
        r_exValid    <= 1'b0;
        r_exRegWrite <= 1'b0;
        r_exMemRead  <= 1'b0;
        if (w_countBubble && (r_bubbleCount != '1)) begin
          r_bubbleCount <= r_bubbleCount + 1'b1;
        end
      end else if (id_valid) begin
        r_exValid    <= 1'b1;
        r_exOpA      <= w_opA;
        r_exOpB      <= w_opB;
        r_exImm      <= id_imm;
        r_exRs       <= id_rs;
        r_exRt       <= id_rt;
        r_exRd       <= id_rd;
        r_exRegWrite <= id_reg_write;
        r_exMemRead  <= id_mem_read;
      end else begin
        r_exValid    <= 1'b0;
        r_exRegWrite <= 1'b0;
        r_exMemRead  <= 1'b0;
      end
    end
  end

  assign ex_valid     = r_exValid;
  assign ex_op_a      = r_exOpA;
  assign ex_op_b      = r_exOpB;
  assign ex_imm       = r_exImm;
  assign ex_rs        = r_exRs;
  assign ex_rt        = r_exRt;
  assign ex_rd        = r_exRd;
  assign ex_reg_write = r_exRegWrite;
  assign ex_mem_read  = r_exMemRead;
  assign bubble_count = r_bubbleCount;

endmodule
`default_nettype wire
